// File: rtl/mult_div_unit.sv
// mult_div_unit: 32-bit signed multiply (radix-2 Booth) and divide (restoring), one bit per cycle.
// Optional MULT_DIV_DIVZERO_EN adds the div_zero flag and a one-cycle divide-by-zero shortcut.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mult_start,
  input  logic        div_start,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
`ifdef MULT_DIV_DIVZERO_EN
  ,
  output logic        div_zero
`endif
);
  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [32:0] acc_q, acc_d;
  logic [31:0] q_q, q_d, m_q, m_d, hi_q, hi_d, lo_q, lo_d;
  logic        q1_q, q1_d, is_div_q, is_div_d, sa_q, sa_d, sb_q, sb_d, done_q, done_d;
  logic [32:0] m_ext, booth_sum, shifted;
  logic [31:0] abs_a, abs_b, rem, rem_s, quo_s;
  logic        ge;
`ifdef MULT_DIV_DIVZERO_EN
  logic        dz_q, dz_d, dzo_q, dzo_d;
  assign div_zero = dzo_q;
`endif
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign done  = done_q;
  assign busy  = (state_q == MULT) || (state_q == DIV);
  assign abs_a = a[31] ? -a : a;
  assign abs_b = b[31] ? -b : b;
  // The accumulator carries one guard bit so subtracting -2^31 cannot overflow.
  assign m_ext     = {m_q[31], m_q};
  assign booth_sum = (q_q[0] && !q1_q) ? acc_q - m_ext :
                     (!q_q[0] && q1_q) ? acc_q + m_ext : acc_q;
  assign shifted   = {acc_q[31:0], q_q[31]};
  assign ge        = shifted >= {1'b0, m_q};
  assign rem       = acc_q[31:0];
  assign rem_s     = sa_q ? -rem : rem;
  assign quo_s     = (sa_q ^ sb_q) ? -q_q : q_q;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    q_d      = q_q;
    q1_d     = q1_q;
    m_d      = m_q;
    is_div_d = is_div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
`ifdef MULT_DIV_DIVZERO_EN
    dz_d     = dz_q;
    dzo_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (mult_start) begin
          state_d  = MULT;
          cnt_d    = 5'd0;
          acc_d    = 33'd0;
          q_d      = b;
          q1_d     = 1'b0;
          m_d      = a;
          is_div_d = 1'b0;
`ifdef MULT_DIV_DIVZERO_EN
          dz_d     = 1'b0;
`endif
        end else if (div_start) begin
          state_d  = DIV;
          cnt_d    = 5'd0;
          acc_d    = 33'd0;
          q_d      = abs_a;
          q1_d     = 1'b0;
          m_d      = abs_b;
          is_div_d = 1'b1;
          sa_d     = a[31];
          sb_d     = b[31];
`ifdef MULT_DIV_DIVZERO_EN
          dz_d     = (b == 32'd0);
          state_d  = (b == 32'd0) ? DONE : DIV;
`endif
        end
      end
      MULT: begin
        acc_d   = {booth_sum[32], booth_sum[32:1]};
        q_d     = {booth_sum[0], q_q[31:1]};
        q1_d    = q_q[0];
        cnt_d   = cnt_q + 5'd1;
        state_d = (cnt_q == 5'd31) ? DONE : MULT;
      end
      DIV: begin
        acc_d   = ge ? shifted - {1'b0, m_q} : shifted;
        q_d     = {q_q[30:0], ge};
        cnt_d   = cnt_q + 5'd1;
        state_d = (cnt_q == 5'd31) ? DONE : DIV;
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
`ifdef MULT_DIV_DIVZERO_EN
        dzo_d   = dz_q;
        hi_d    = dz_q ? hi_q : is_div_q ? rem_s : acc_q[31:0];
        lo_d    = dz_q ? lo_q : is_div_q ? quo_s : q_q;
`else
        hi_d    = is_div_q ? rem_s : acc_q[31:0];
        lo_d    = is_div_q ? quo_s : q_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      acc_q    <= 33'd0;
      q_q      <= 32'd0;
      q1_q     <= 1'b0;
      m_q      <= 32'd0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
`ifdef MULT_DIV_DIVZERO_EN
      dz_q     <= 1'b0;
      dzo_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      q1_q     <= q1_d;
      m_q      <= m_d;
      is_div_q <= is_div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
`ifdef MULT_DIV_DIVZERO_EN
      dz_q     <= dz_d;
      dzo_q    <= dzo_d;
`endif
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: table-driven directed vectors for mult_div_unit plus hand sequences
// for start collision, mid-operation restart attempts and reset abort.
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        reset, mult_start, div_start;
  logic [31:0] a, b, hi, lo;
  logic        busy, done;
`ifdef MULT_DIV_DIVZERO_EN
  logic        div_zero;
`endif
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  mult_div_unit dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .mult_start(mult_start), .div_start(div_start),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
`ifdef MULT_DIV_DIVZERO_EN
    , .div_zero(div_zero)
`endif
  );
  typedef struct {
    logic [31:0] a, b;
    logic        dv;
    logic [31:0] eh, el;
    int          lat;
    logic        dz;
  } vec_t;
  vec_t tbl[12];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run_vec(input vec_t v, input logic both, input int pulse_at);
    logic [31:0] ph, pl;
    int          lat;
    logic        stable;
    @(negedge clk);
    reset = 1'b0;
    a = v.a;
    b = v.b;
    mult_start = !v.dv || both;
    div_start  = v.dv || both;
    @(posedge clk);
    #1;
    mult_start = 1'b0;
    div_start  = 1'b0;
    a = $urandom;
    b = $urandom;
    ph = hi;
    pl = lo;
    lat = 0;
    stable = 1'b1;
    chk("busy_after_start", {31'b0, busy}, {31'b0, v.lat != 1});
    while (!done && lat < 40) begin
      div_start = (pulse_at >= 0) && (lat == pulse_at);
      @(posedge clk);
      #1;
      lat++;
      if (!done && (hi !== ph || lo !== pl)) stable = 1'b0;
    end
    div_start = 1'b0;
    chk("latency", lat, v.lat);
    chk("hi", hi, v.eh);
    chk("lo", lo, v.el);
    chk("hold_while_busy", {31'b0, stable}, 32'd1);
    chk("busy_at_done", {31'b0, busy}, 32'd0);
`ifdef MULT_DIV_DIVZERO_EN
    chk("div_zero", {31'b0, div_zero}, {31'b0, v.dz});
`endif
    @(posedge clk);
    #1;
    chk("done_one_cycle", {31'b0, done}, 32'd0);
  endtask
  task automatic count_dones(input string name, input int cycles);
    int k = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (done) k++;
    end
    chk(name, k, 0);
  endtask
  initial begin
    vec_t v;
    tbl[0]  = '{32'h00000007, 32'hFFFFFFFD, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, 1'b0};
    tbl[1]  = '{32'hFFFFFFF9, 32'h00000002, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0};
    tbl[2]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h80000000, 33, 1'b0};
`ifdef MULT_DIV_DIVZERO_EN
    tbl[3]  = '{32'h00000005, 32'h00000000, 1'b1, 32'h00000000, 32'h80000000, 1, 1'b1};
`else
    tbl[3]  = '{32'h00000005, 32'h00000000, 1'b1, 32'h00000005, 32'hFFFFFFFF, 33, 1'b0};
`endif
    tbl[4]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000, 33, 1'b0};
    tbl[5]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h00000001, 33, 1'b0};
    tbl[6]  = '{32'd100,      32'd7,        1'b1, 32'h00000002, 32'h0000000E, 33, 1'b0};
    tbl[7]  = '{32'h00000007, 32'hFFFFFFFE, 1'b1, 32'h00000001, 32'hFFFFFFFD, 33, 1'b0};
    tbl[8]  = '{32'h12345678, 32'h00000010, 1'b0, 32'h00000001, 32'h23456780, 33, 1'b0};
    tbl[9]  = '{32'hFFFFFFF8, 32'hFFFFFFFE, 1'b1, 32'h00000000, 32'h00000004, 33, 1'b0};
    tbl[10] = '{32'h0000FFFF, 32'h0000FFFF, 1'b0, 32'h00000000, 32'hFFFE0001, 33, 1'b0};
    tbl[11] = '{32'h7FFFFFFF, 32'h00000001, 1'b1, 32'h00000000, 32'h7FFFFFFF, 33, 1'b0};
    reset = 1'b1;
    mult_start = 1'b0;
    div_start = 1'b0;
    a = 32'd0;
    b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy_done", {30'b0, busy, done}, 32'd0);
`ifdef MULT_DIV_DIVZERO_EN
    chk("reset_div_zero", {31'b0, div_zero}, 32'd0);
`endif
    for (int i = 0; i < 12; i++) run_vec(tbl[i], 1'b0, -1);
    // Both starts together: multiply wins; a later div_start pulse while busy is dropped.
    v = '{32'd3, 32'd4, 1'b0, 32'd0, 32'd12, 33, 1'b0};
    run_vec(v, 1'b1, 5);
    count_dones("no_queued_div", 40);
    // Reset ten cycles into a divide aborts it without a done pulse.
    @(negedge clk);
    a = 32'd100;
    b = 32'd7;
    div_start = 1'b1;
    @(negedge clk);
    div_start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    count_dones("abort_no_done", 40);
    v = '{32'd2, 32'd2, 1'b0, 32'd0, 32'd4, 33, 1'b0};
    run_vec(v, 1'b0, -1);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
